// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 5-stage pipeline.
// It runs one imem request at a time, owns the IF/ID slot, and drives the
// PC register load enable and next address. Branch and jump redirects are
// applied after the delay slot. Bad PCs and memory timeouts cause a sticky fault.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6FFC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    FETCH     = 2'd1,
    WAIT_SLOT = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

  state_t      state_q;
  logic        busy_q;        // request outstanding, waiting for ack
  logic [4:0]  tmo_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic        fault_q;
  logic [1:0]  code_q;

  logic        accept;
  logic        slot_free;
  logic        misaligned;
  logic        out_range;
  logic        pc_bad;
  logic        req;
  logic        ack;
  logic        redir_take;
  logic        timeout_hit;
  logic [31:0] next_pc_d;

  assign accept      = if_valid_q & ~id_stall;
  assign slot_free   = ~if_valid_q | accept;
  assign misaligned  = (pc[1:0] != 2'b00);
  assign out_range   = (pc < PC_MIN) | (pc > PC_MAX);
  assign pc_bad      = misaligned | out_range;
  // The PC is checked before a request goes out. Once a request is in flight,
  // the slot stays free and the PC stays stable until the ack.
  assign req         = (state_q == FETCH) & ~pc_bad & (busy_q | slot_free);
  assign ack         = req & imem_ack;
  // Only the first redirect counts until it has been used by the delay-slot ack.
  assign redir_take  = accept & redirect_valid & ~redir_pend_q;
  assign timeout_hit = req & ~imem_ack & (tmo_q == TMO_LAST);

  // Next PC value: a pending redirect, a same-cycle redirect, or sequential.
  always_comb begin
    next_pc_d = pc + 32'd4;
    if (state_q == BOOT) begin
      next_pc_d = RESET_PC;
    end else if (ack && redir_pend_q) begin
      next_pc_d = redir_tgt_q;
    end else if (ack && redir_take) begin
      next_pc_d = redirect_target;
    end
  end

  // Sequencer FSM: request tracking, timeout counter and sticky fault reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      busy_q  <= 1'b0;
      tmo_q   <= 5'd0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      case (state_q)
        BOOT: state_q <= FETCH;
        FETCH: begin
          if (pc_bad) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            code_q  <= misaligned ? 2'b01 : 2'b10;
            busy_q  <= 1'b0;
          end else if (timeout_hit) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            code_q  <= 2'b11;
            busy_q  <= 1'b0;
          end else if (ack) begin
            busy_q <= 1'b0;
            tmo_q  <= 5'd0;
            if (!slot_free) state_q <= WAIT_SLOT;
          end else begin
            busy_q <= req;
            if (req) tmo_q <= tmo_q + 5'd1;
          end
        end
        WAIT_SLOT: if (accept) state_q <= FETCH;
        default: state_q <= FAULT;
      endcase
    end
  end

  // Redirect latch: it holds a redirect taken before the delay slot has been fetched.
  always_ff @(posedge clk) begin
    if (reset) begin
      redir_pend_q <= 1'b0;
    end else if (ack && redir_pend_q) begin
      redir_pend_q <= 1'b0;
    end else if (redir_take && !ack) begin
      redir_pend_q <= 1'b1;
    end
  end

  // Redirect target storage. Its contents matter only while a redirect is pending.
  always_ff @(posedge clk) begin
    if (redir_take && !ack) redir_tgt_q <= redirect_target;
  end

  // Holding buffer for a fetch that completes while the slot is still occupied.
  always_ff @(posedge clk) begin
    if (ack && !slot_free) begin
      buf_instr_q <= imem_rdata;
      buf_pc_q    <= pc;
    end
  end

  // IF/ID slot: filled from memory or the buffer, cleared when decode takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q <= 1'b0;
      if_instr_q <= 32'd0;
      if_pc_q    <= 32'd0;
    end else if (ack && slot_free) begin
      if_valid_q <= 1'b1;
      if_instr_q <= imem_rdata;
      if_pc_q    <= pc;
    end else if ((state_q == WAIT_SLOT) && accept) begin
      if_valid_q <= 1'b1;
      if_instr_q <= buf_instr_q;
      if_pc_q    <= buf_pc_q;
    end else if (accept) begin
      if_valid_q <= 1'b0;
    end
  end

  assign pc_en       = ack;
  assign next_pc     = next_pc_d;
  assign imem_req    = req;
  assign imem_addr   = pc;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_fault = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized bench for fetch_ctrl.
// The reference is a transaction model. Each ack consumes the next expected
// fetch address, and that address advances by +4 or to a pending redirect.
// Fetched words pass through an in-order queue that the accepted slot must match.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .fetch_fault(fetch_fault), .fault_code(fault_code)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } item_t;

  int vectors = 0;
  int miscompares = 0;

  item_t       q[$];
  logic [31:0] ack_log[$];
  logic [31:0] npc_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_next;
  logic [31:0] m_tgt;
  bit          m_pend;
  logic [31:0] pc_nxt;

  int          lat_fixed;
  int          lat_cur;
  int          wait_cnt;
  int          req_run;
  int          stall_mode;
  bit          ack_en;
  bit          redir_rand;
  bit          redir_force;
  logic [31:0] force_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n, input bit late_ack);
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
    pc = RESET_PC;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_next_pc", next_pc, RESET_PC);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    chk("rst_fault_code", fault_code, 0);
    reset = 1'b0;
    imem_ack = late_ack;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("boot_pc_en", pc_en, 0);
    chk("boot_imem_req", imem_req, 0);
    q.delete(); ack_log.delete(); npc_log.delete(); acc_log.delete();
    m_next = RESET_PC; m_pend = 1'b0; pc_nxt = RESET_PC;
    wait_cnt = 0; req_run = 0; redir_force = 1'b0;
    lat_cur = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
  endtask

  task automatic step();
    bit          accept;
    logic [31:0] exp_np;
    @(negedge clk);
    pc = pc_nxt;
    imem_ack = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    case (stall_mode)
      0:       id_stall = 1'b0;
      1:       id_stall = 1'b1;
      default: id_stall = ($urandom_range(0, 2) == 0);
    endcase
    #1;
    if (if_valid && !id_stall && (redir_force || (redir_rand && $urandom_range(0, 4) == 0))) begin
      redirect_valid = 1'b1;
      redirect_target = redir_force ? force_tgt : (32'h3000 + ($urandom_range(0, 4095) << 2));
      redir_force = 1'b0;
    end
    if (imem_req) begin
      req_run++;
      if (ack_en && wait_cnt >= lat_cur) begin
        imem_ack = 1'b1;
        imem_rdata = $urandom;
      end else begin
        wait_cnt++;
      end
    end
    #1;
    chk("pc_en_vs_ack", pc_en, imem_ack);
    if (imem_req) chk("imem_addr_eq_pc", imem_addr, pc);
    if (if_valid && id_stall) chk("no_req_while_stalled", imem_req, 0);
    chk("if_valid", if_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("if_instr", if_instr, q[0].instr);
      chk("if_pc", if_pc, q[0].addr);
    end
    accept = if_valid && !id_stall;
    if (accept && q.size() != 0) begin
      acc_log.push_back(q[0].addr);
      void'(q.pop_front());
    end
    if (accept && redirect_valid && !m_pend) begin
      m_pend = 1'b1;
      m_tgt = redirect_target;
    end
    if (imem_ack) begin
      exp_np = m_pend ? m_tgt : m_next + 32'd4;
      chk("fetch_addr", imem_addr, m_next);
      chk("next_pc", next_pc, exp_np);
      if (lat_fixed >= 0) chk("req_cycles", req_run, lat_fixed + 1);
      q.push_back('{m_next, imem_rdata});
      ack_log.push_back(m_next);
      npc_log.push_back(next_pc);
      m_next = exp_np; m_pend = 1'b0; req_run = 0; wait_cnt = 0;
      lat_cur = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
    end
    pc_nxt = pc_en ? next_pc : pc;
  endtask

  initial begin
    logic [31:0] save_instr;
    logic [31:0] save_pc;
    int          req_hi;
    reset = 1'b0; pc = RESET_PC; imem_ack = 1'b0; imem_rdata = 32'd0;
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    stall_mode = 0; ack_en = 1'b1; redir_rand = 1'b0; redir_force = 1'b0;
    force_tgt = 32'd0; lat_fixed = 0;

    // Back-to-back fetches with ack in the request cycle.
    lat_fixed = 0;
    do_reset(2, 1'b0);
    repeat (6) step();
    chk("t1_ack_count", ack_log.size() >= 2, 1);
    chk("t1_addr0", ack_log[0], 32'h3000);
    chk("t1_addr1", ack_log[1], 32'h3004);
    chk("t1_npc0", npc_log[0], 32'h3004);
    chk("t1_npc1", npc_log[1], 32'h3008);
    chk("t1_slot0", acc_log[0], 32'h3000);
    chk("t1_slot1", acc_log[1], 32'h3004);

    // Fixed memory latency: the request stays high for 3 cycles per fetch.
    lat_fixed = 2;
    do_reset(2, 1'b0);
    repeat (20) step();
    chk("t2_ack_count", ack_log.size() >= 4, 1);

    // Decode stalls with a full slot: the slot holds and no new request goes out.
    lat_fixed = 0; stall_mode = 1;
    do_reset(2, 1'b0);
    repeat (3) step();
    chk("t3_slot_full", if_valid, 1);
    save_instr = if_instr; save_pc = if_pc; req_hi = 0;
    repeat (4) begin
      step();
      if (imem_req) req_hi++;
      chk("t3_instr_hold", if_instr, save_instr);
      chk("t3_pc_hold", if_pc, save_pc);
    end
    chk("t3_no_req", req_hi, 0);
    chk("t3_one_fetch", ack_log.size(), 1);
    stall_mode = 0;
    repeat (5) step();

    // Branch at 0x3000 with delay slot: the pending-redirect path, then the same-cycle path.
    for (int lat = 2; lat >= 0; lat -= 2) begin
      lat_fixed = lat;
      do_reset(2, 1'b0);
      redir_force = 1'b1; force_tgt = 32'h3100;
      repeat (15) step();
      chk("t4_ack_count", ack_log.size() >= 3, 1);
      chk("t4_branch", ack_log[0], 32'h3000);
      chk("t4_delay_slot", ack_log[1], 32'h3004);
      chk("t4_delay_npc", npc_log[1], 32'h3100);
      chk("t4_target", ack_log[2], 32'h3100);
    end

    // Redirects to illegal targets raise a sticky fault and stop requests.
    lat_fixed = 1;
    do_reset(2, 1'b0);
    redir_force = 1'b1; force_tgt = 32'h3102;
    repeat (12) step();
    chk("t5_mis_fault", fetch_fault, 1);
    chk("t5_mis_code", fault_code, 2'b01);
    chk("t5_mis_req", imem_req, 0);
    chk("t5_mis_fetches", ack_log.size(), 2);
    repeat (5) step();
    chk("t5_mis_sticky", fetch_fault, 1);
    do_reset(2, 1'b0);
    redir_force = 1'b1; force_tgt = 32'h7000;
    repeat (12) step();
    chk("t5_range_fault", fetch_fault, 1);
    chk("t5_range_code", fault_code, 2'b10);
    chk("t5_range_req", imem_req, 0);

    // Memory never acks: timeout after 16 request cycles. Then reset with a late ack.
    lat_fixed = -1; ack_en = 1'b0;
    do_reset(2, 1'b0);
    repeat (30) step();
    chk("t6_req_cycles", req_run, 16);
    chk("t6_fault", fetch_fault, 1);
    chk("t6_code", fault_code, 2'b11);
    chk("t6_req_dropped", imem_req, 0);
    ack_en = 1'b1; lat_fixed = 0;
    do_reset(2, 1'b1);
    repeat (4) step();
    chk("t6_resume_addr", ack_log[0], 32'h3000);
    chk("t6_fault_clear", fetch_fault, 0);
    lat_fixed = 4;
    do_reset(2, 1'b0);
    repeat (3) step();
    do_reset(1, 1'b1);
    repeat (10) step();
    chk("t6_midreq_addr", ack_log[0], 32'h3000);

    // Randomized latency, stalls and redirects against the transaction model.
    lat_fixed = -1; stall_mode = 2; redir_rand = 1'b1;
    do_reset(2, 1'b0);
    repeat (3000) step();
    chk("t7_no_fault", fetch_fault, 0);
    chk("t7_progress", ack_log.size() > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
